// File: rtl/uart_send_if.sv
// Read-side handshake between an upstream byte FIFO and the UART transmitter.
// The transmitter (slave) pops with data_out_read and reads data_out one clk later.
interface uart_send_if;
    logic       data_out_empty;
    logic [7:0] data_out;
    logic       data_out_read;

    modport master (
        output data_out_empty,
        output data_out,
        input  data_out_read
    );

    modport slave (
        input  data_out_empty,
        input  data_out,
        output data_out_read
    );
endinterface

// File: rtl/uart_send.sv
// FIFO-fed UART transmitter, 8N1 by default, bit timing from an oversampled baud_tick.
// Define UART_SEND_PARITY_EN to insert an even-parity bit between data bit 7 and stop.
//
// state  | meaning
// IDLE   | line high, pop the FIFO as soon as it is non-empty
// POP    | pop strobe high, FIFO data not yet valid
// LOAD   | capture FIFO data, start bit driven from the next clk
// START  | start bit (low)
// DATA   | data bits 0..7, LSB first
// PARITY | even-parity bit (only with UART_SEND_PARITY_EN)
// STOP   | STOP_BITS stop bits (high)
module uart_send #(
    parameter int OVERSAMPLE = 16,
    parameter int STOP_BITS  = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       baud_tick,
    uart_send_if.slave fifo,
    output logic       tx_wire,
    output logic       tx_busy
);

    localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] POP    = 3'd1;
    localparam logic [2:0] LOAD   = 3'd2;
    localparam logic [2:0] START  = 3'd3;
    localparam logic [2:0] DATA   = 3'd4;
    localparam logic [2:0] STOP   = 3'd5;
`ifdef UART_SEND_PARITY_EN
    localparam logic [2:0] PARITY = 3'd6;
`endif

    logic [2:0]    state;
    logic [TW-1:0] tick_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift;
    logic          in_bit;
    logic          bit_end;
`ifdef UART_SEND_PARITY_EN
    logic          par_bit;
`endif

    // Ticks are only counted while a bit is on the line; POP/LOAD ticks are dropped.
    always_comb begin
        in_bit = (state == START) || (state == DATA) || (state == STOP);
`ifdef UART_SEND_PARITY_EN
        if (state == PARITY) in_bit = 1'b1;
`endif
        bit_end = in_bit && baud_tick && (tick_cnt == TICK_LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= IDLE;
            tick_cnt           <= '0;
            bit_cnt            <= '0;
            shift              <= '0;
            tx_wire            <= 1'b1;
            tx_busy            <= 1'b0;
            fifo.data_out_read <= 1'b0;
`ifdef UART_SEND_PARITY_EN
            par_bit            <= 1'b0;
`endif
        end else begin
            fifo.data_out_read <= 1'b0;

            if (in_bit && baud_tick) begin
                if (bit_end) tick_cnt <= '0;
                else         tick_cnt <= tick_cnt + 1'b1;
            end

            case (state)
                IDLE: begin
                    if (!fifo.data_out_empty) begin
                        fifo.data_out_read <= 1'b1;
                        tx_busy            <= 1'b1;
                        state              <= POP;
                    end
                end
                POP: begin
                    state <= LOAD;
                end
                LOAD: begin
                    shift    <= fifo.data_out;
                    tick_cnt <= '0;
                    bit_cnt  <= '0;
`ifdef UART_SEND_PARITY_EN
                    par_bit  <= ^fifo.data_out;
`endif
                    tx_wire  <= 1'b0;
                    state    <= START;
                end
                START: begin
                    if (bit_end) begin
                        tx_wire <= shift[0];
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (bit_cnt == 3'd7) begin
                            bit_cnt <= '0;
`ifdef UART_SEND_PARITY_EN
                            tx_wire <= par_bit;
                            state   <= PARITY;
`else
                            tx_wire <= 1'b1;
                            state   <= STOP;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            shift   <= {1'b0, shift[7:1]};
                            tx_wire <= shift[1];
                        end
                    end
                end
`ifdef UART_SEND_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        tx_wire <= 1'b1;
                        state   <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (bit_end) begin
                        if (bit_cnt == STOP_LAST) begin
                            bit_cnt <= '0;
                            tx_busy <= 1'b0;
                            state   <= IDLE;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end
                end
                default: begin
                    tx_wire <= 1'b1;
                    tx_busy <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_send.sv
// Directed bench for uart_send: a default instance (ticks every 4 clk) and an
// OVERSAMPLE=4/STOP_BITS=2 instance with irregular ticks, each fed by a small FIFO model.
module tb_uart_send;

    localparam int OS_A = 16;
    localparam int SB_A = 1;
    localparam int OS_B = 4;
    localparam int SB_B = 2;
`ifdef UART_SEND_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif

    typedef struct {
        logic [7:0] data;
        logic [7:0] exp_byte;
        logic       exp_par;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic tick_a = 1'b0;
    logic tick_b = 1'b0;
    logic tx_a, busy_a, tx_b, busy_b;

    int cyc = 0;
    int ph_a = 0;
    int ph_b = 0;
    int reads_a = 0, reads_b = 0, read_err_a = 0, read_err_b = 0;
    logic prev_busy_a = 1'b0, prev_read_a = 1'b0, prev_busy_b = 1'b0, prev_read_b = 1'b0;
    logic [7:0] q_a[$];
    logic [7:0] q_b[$];
    int n_checks = 0;
    int n_pass = 0;

    uart_send_if bus_a();
    uart_send_if bus_b();

    uart_send #(.OVERSAMPLE(OS_A), .STOP_BITS(SB_A)) dut_a (
        .clk(clk), .rst_n(rst_n), .baud_tick(tick_a), .fifo(bus_a.slave),
        .tx_wire(tx_a), .tx_busy(busy_a)
    );

    uart_send #(.OVERSAMPLE(OS_B), .STOP_BITS(SB_B)) dut_b (
        .clk(clk), .rst_n(rst_n), .baud_tick(tick_b), .fifo(bus_b.slave),
        .tx_wire(tx_b), .tx_busy(busy_b)
    );

    always #5 clk = ~clk;

    // Tick sources: A every 4 clk, B with gaps alternating 1 and 7 clk.
    always @(negedge clk) begin
        cyc++;
        ph_a   = (ph_a + 1) % 4;
        tick_a = (ph_a == 0);
        ph_b   = (ph_b == 9) ? 0 : ph_b + 1;
        tick_b = (ph_b == 0) || (ph_b == 2);
    end

    // FIFO models: a pop strobe seen in a cycle presents the head byte for the next edge.
    always @(negedge clk) begin
        if (bus_a.data_out_read === 1'b1) begin
            reads_a++;
            if (prev_busy_a !== 1'b0 || prev_read_a === 1'b1) read_err_a++;
            if (q_a.size() > 0) bus_a.data_out = q_a.pop_front();
            bus_a.data_out_empty = (q_a.size() == 0);
        end
        prev_busy_a = busy_a;
        prev_read_a = bus_a.data_out_read;
        if (bus_b.data_out_read === 1'b1) begin
            reads_b++;
            if (prev_busy_b !== 1'b0 || prev_read_b === 1'b1) read_err_b++;
            if (q_b.size() > 0) bus_b.data_out = q_b.pop_front();
            bus_b.data_out_empty = (q_b.size() == 0);
        end
        prev_busy_b = busy_b;
        prev_read_b = bus_b.data_out_read;
    end

    function automatic logic tx_of(input int w);
        return (w == 0) ? tx_a : tx_b;
    endfunction

    function automatic logic busy_of(input int w);
        return (w == 0) ? busy_a : busy_b;
    endfunction

    function automatic logic tick_of(input int w);
        return (w == 0) ? tick_a : tick_b;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic push_a(input logic [7:0] d);
        q_a.push_back(d);
        bus_a.data_out_empty = 1'b0;
    endtask

    task automatic push_b(input logic [7:0] d);
        q_b.push_back(d);
        bus_b.data_out_empty = 1'b0;
    endtask

    // Align so that instance A sees its first tick in the 4th clk of the start bit.
    task automatic align_a();
        int n;
        n = 0;
        do begin @(negedge clk); #1; n++; end while (ph_a != 2 && n < 10);
    endtask

    // Receives one frame by tick windows: bit k spans the cycles after k*os ticks
    // and up to and including the cycle carrying tick (k+1)*os.
    task automatic run_frame(input int w, output logic [7:0] byte_o, output logic par_o,
                             output int start_c, output int end_c, output int glitch,
                             output int frame_err, output int bad_len, output int timeout);
        int os, nb, total, prior, k, n;
        logic bits[12];
        int cnt[12];
        os = (w == 0) ? OS_A : OS_B;
        nb = 9 + PB + ((w == 0) ? SB_A : SB_B);
        total = nb * os;
        byte_o = '0; par_o = 1'b0; start_c = 0; end_c = 0;
        glitch = 0; frame_err = 0; bad_len = 0; timeout = 0;
        for (int i = 0; i < 12; i++) begin cnt[i] = 0; bits[i] = 1'b1; end
        n = 0;
        do begin @(negedge clk); #1; n++; end while (tx_of(w) !== 1'b0 && n < 5000);
        if (tx_of(w) !== 1'b0) begin
            timeout = 1;
            return;
        end
        start_c = cyc;
        prior = 0;
        while (prior < total) begin
            k = prior / os;
            if (cnt[k] == 0) bits[k] = tx_of(w);
            else if (tx_of(w) !== bits[k]) glitch++;
            cnt[k]++;
            if (busy_of(w) !== 1'b1) frame_err++;
            if (tick_of(w) === 1'b1) prior++;
            end_c = cyc;
            if (prior < total) begin @(negedge clk); #1; end
        end
        @(negedge clk); #1;
        if (busy_of(w) !== 1'b0 || tx_of(w) !== 1'b1) frame_err++;
        for (int i = 0; i < 8; i++) byte_o[i] = bits[i+1];
        par_o = bits[9];
        for (int i = 9 + PB; i < nb; i++) if (bits[i] !== 1'b1) frame_err++;
        if (w == 0) for (int i = 0; i < nb; i++) if (cnt[i] != os * 4) bad_len++;
    endtask

    vec_t vecs[4];

    initial begin
        logic [7:0] rx, rx2;
        logic par, par2;
        int s1, e1, s2, e2, gl, fe, bl, to, r0, n, tk, viol;

        vecs[0] = '{8'h55, 8'h55, 1'b0};
        vecs[1] = '{8'h07, 8'h07, 1'b1};
        vecs[2] = '{8'h03, 8'h03, 1'b0};
        vecs[3] = '{8'hC4, 8'hC4, 1'b1};

        bus_a.data_out_empty = 1'b1;
        bus_a.data_out = 8'h00;
        bus_b.data_out_empty = 1'b1;
        bus_b.data_out = 8'h00;

        repeat (3) @(negedge clk);
        #1;
        check("reset_tx_a", tx_a, 1);
        check("reset_busy_a", busy_a, 0);
        check("reset_read_a", bus_a.data_out_read, 0);
        check("reset_tx_b", tx_b, 1);
        check("reset_busy_b", busy_b, 0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Single frames on the default instance
        foreach (vecs[i]) begin
            r0 = reads_a;
            align_a();
            push_a(vecs[i].data);
            run_frame(0, rx, par, s1, e1, gl, fe, bl, to);
            check($sformatf("vec%0d_timeout", i), to, 0);
            check($sformatf("vec%0d_byte", i), rx, vecs[i].exp_byte);
`ifdef UART_SEND_PARITY_EN
            check($sformatf("vec%0d_parity", i), par, vecs[i].exp_par);
`endif
            check($sformatf("vec%0d_glitch", i), gl, 0);
            check($sformatf("vec%0d_frame", i), fe, 0);
            check($sformatf("vec%0d_bit_len64", i), bl, 0);
            check($sformatf("vec%0d_reads", i), reads_a - r0, 1);
        end

        // Back-to-back 0xA3, 0x0F
        r0 = reads_a;
        align_a();
        push_a(8'hA3);
        push_a(8'h0F);
        run_frame(0, rx, par, s1, e1, gl, fe, bl, to);
        check("b2b_first_byte", rx, 8'hA3);
        check("b2b_first_frame", fe + gl + to, 0);
        check("b2b_first_len", bl, 0);
        run_frame(0, rx2, par2, s2, e2, gl, fe, bl, to);
        check("b2b_second_byte", rx2, 8'h0F);
        check("b2b_second_frame", fe + gl + to, 0);
        check("b2b_gap_clk", s2 - e1, 4);
        check("b2b_reads", reads_a - r0, 2);
        check("read_from_idle_a", read_err_a, 0);

        // Empty FIFO with ticks running
        r0 = reads_a;
        viol = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk); #1;
            if (tx_a !== 1'b1 || busy_a !== 1'b0 || bus_a.data_out_read !== 1'b0) viol++;
        end
        check("empty_idle_violations", viol, 0);
        check("empty_no_reads", reads_a - r0, 0);

        // Irregular ticks, OVERSAMPLE=4, two stop bits
        push_b(8'h81);
        run_frame(1, rx, par, s1, e1, gl, fe, bl, to);
        check("irr_timeout", to, 0);
        check("irr_byte", rx, 8'h81);
`ifdef UART_SEND_PARITY_EN
        check("irr_parity", par, 0);
`endif
        check("irr_glitch", gl, 0);
        check("irr_frame", fe, 0);
        check("irr_reads", reads_b, 1);
        check("read_from_idle_b", read_err_b, 0);

        // Reset during data bit 3 of 0xF0
        r0 = reads_a;
        push_a(8'hF0);
        n = 0;
        do begin @(negedge clk); #1; n++; end while (tx_a !== 1'b0 && n < 200);
        check("rst_start_seen", tx_a, 0);
        tk = 0;
        n = 0;
        while (tk < 4 * OS_A + 6 && n < 2000) begin
            if (tick_a === 1'b1) tk++;
            @(negedge clk); #1;
            n++;
        end
        check("rst_in_bit3_low", tx_a, 0);
        check("rst_in_bit3_busy", busy_a, 1);
        rst_n = 1'b0;
        #1;
        check("rst_async_tx", tx_a, 1);
        check("rst_async_busy", busy_a, 0);
        check("rst_async_read", bus_a.data_out_read, 0);
        push_a(8'h3C);
        repeat (3) @(negedge clk);
        #1;
        check("rst_hold_tx", tx_a, 1);
        rst_n = 1'b1;
        run_frame(0, rx, par, s1, e1, gl, fe, bl, to);
        check("rst_fresh_timeout", to, 0);
        check("rst_fresh_byte", rx, 8'h3C);
        check("rst_fresh_frame", fe + gl, 0);
        check("rst_fresh_reads", reads_a - r0, 2);

        repeat (20) @(negedge clk);
        #1;
        check("final_idle_tx", tx_a, 1);
        check("final_idle_busy", busy_a, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_send.md
Name: uart_send

Overview:
- Transmit-side counterpart of the UART receive path.
- Pops bytes from an upstream FIFO (read-side handshake) and serialises each one onto `tx_wire` as 8N1 (or 8E1 with the option): LSB first, idle-high line.
- Bit timing comes from the shared `baud_tick` enable, which is an oversampled pulse, so the same tick generator drives both RX and TX.

Parameters:
- OVERSAMPLE, 16, `baud_tick` pulses per bit period; legal range 2..64.
- STOP_BITS, 1, number of stop bits (1 or 2).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- baud_tick  input  1  one-clk-wide enable pulse at OVERSAMPLE x baud rate
- data_out_empty  input  1  upstream FIFO empty flag
- data_out  input  8  FIFO read data; valid the clk after `data_out_read`
- data_out_read  output  1  one-clk FIFO pop strobe
- tx_wire  output  1  serial line, idle high
- tx_busy  output  1  high from pop until the end of the last stop bit

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-frame):
  - `tx_wire`=1, `data_out_read`=0, `tx_busy`=0, state=IDLE.
  - Tick counter, bit counter and shift register cleared.
  - A frame cut by reset is abandoned, never resumed, and the byte is lost.
- States: IDLE, POP, LOAD, START, DATA, PARITY (option only), STOP.
- IDLE:
  - If `data_out_empty`=0, assert `data_out_read` for exactly one clk and go to POP.
  - If `data_out_empty`=1, never assert `data_out_read`.
- POP:
  - `data_out_read` returns to 0; wait one clk for FIFO data.
  - Go to LOAD; `tx_busy`=1 from the POP cycle onward.
- LOAD:
  - Capture `data_out` into the shift register and clear the tick counter.
  - Drive `tx_wire`=0 and go to START. The start bit begins the clk after LOAD.
- Bit timing:
  - Each bit (start, data, parity, stop) lasts exactly OVERSAMPLE `baud_tick` pulses, counted from the first tick after the bit begins.
  - The bit ends on the clk where the OVERSAMPLE-th tick is seen. `tx_wire` changes on the following clk edge.
  - Clk cycles without `baud_tick` do not advance the counter.
- START: after OVERSAMPLE ticks, go to DATA and drive bit 0.
- DATA:
  - Bits 0..7, LSB first; 3-bit bit counter.
  - After bit 7, go to PARITY (option) or STOP.
- STOP:
  - `tx_wire`=1 for STOP_BITS x OVERSAMPLE ticks.
  - Then `tx_busy`=0 and return to IDLE.
- Back-to-back frames:
  - IDLE may pop in the same clk it is entered.
  - The next start bit begins 3 clk after the last stop bit ends, with no extra idle bit time.
- Empty mid-stream: remain in IDLE with `tx_wire`=1, `tx_busy`=0, indefinitely.
- `data_out_empty` is sampled only in IDLE; changes during a frame are ignored.
- `baud_tick` coincident with a LOAD or POP cycle is not counted.
- `tx_wire` is driven from a flop; there is no combinational path from any input.

Optional Feature:
- Macro: `UART_SEND_PARITY_EN`.
- Defined:
  - PARITY state inserted between bit 7 and STOP; lasts OVERSAMPLE ticks.
  - Drives the even-parity bit, the XOR of the 8 data bits captured in LOAD.
  - Frame = 1 start + 8 data + 1 parity + STOP_BITS.
- Undefined:
  - PARITY state and its logic absent; frame = 1 start + 8 data + STOP_BITS.

Test Plan:
- Single byte, defaults, `baud_tick` every 4 clk, FIFO holds 0x55:
  - exactly one `data_out_read` pulse.
  - `tx_wire` shows 0,1,0,1,0,1,0,1,0,1 (start, LSB-first data, stop), each level 64 clk.
  - `tx_busy` falls after the stop bit; the line stays high afterwards.
- Back-to-back, FIFO holds 0xA3 then 0x0F:
  - two reads, each issued only from IDLE.
  - Second start bit begins 3 clk after the first stop bit ends.
  - Decoded bytes 0xA3, 0x0F.
- Empty FIFO, `data_out_empty`=1 for 1000 clk with ticks running:
  - `data_out_read` never asserts; `tx_wire`=1, `tx_busy`=0 throughout.
- Reset mid-frame: assert `rst_n`=0 during data bit 3 of 0xF0:
  - `tx_wire`=1 and `tx_busy`=0 immediately, before the next clk edge.
  - After release with the FIFO non-empty, a fresh frame starts with a new pop.
- Irregular ticks, OVERSAMPLE=4, STOP_BITS=2, `baud_tick` gaps alternating 1 and 7 clk:
  - every bit spans exactly 4 ticks; stop level spans 8 ticks.
  - Byte 0x81 is decoded correctly.
- With `UART_SEND_PARITY_EN`, bytes 0x07 and 0x03:
  - 0x07 gives parity bit 1; 0x03 gives parity bit 0.
  - Each parity bit lasts OVERSAMPLE ticks, between bit 7 and stop.
